// File: rtl/seg_mux_if.sv
// seg_mux_if: digit-producer / display-side signals of the segment multiplexer.
// The producer (master) drives digits_in and load. The multiplexer (slave) drives
// num, dig_en_n and frame_done.
// Handshake: load is a single-cycle strobe with no ready. Every rising clk edge
// that sees load=1 is one transfer of digits_in, and the multiplexer always accepts it.
interface seg_mux_if #(
  parameter int NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic [3:0]              num;
  logic [NUM_DIGITS-1:0]   dig_en_n;
  logic                    frame_done;

  modport master (
    output digits_in,
    output load,
    input  num,
    input  dig_en_n,
    input  frame_done
  );

  modport slave (
    input  digits_in,
    input  load,
    output num,
    output dig_en_n,
    output frame_done
  );
endinterface

// File: rtl/seg_mux_ctrl.sv
// seg_mux_ctrl: time-multiplexes NUM_DIGITS hex digits onto one shared seven-segment
// decoder. Each digit slot is BLANK_CYCLES dark cycles followed by DWELL_CYCLES lit cycles.
// New digit values wait in a shadow register and are committed only at frame boundaries,
// so a frame never shows a mix of old and new digits.
// Optional feature macro: SEG_MUX_LZB_EN enables leading-zero blanking.
// dbg_state exposes the FSM state (0 = BLANK, 1 = DRIVE).
module seg_mux_ctrl #(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 48_000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic     clk,
  input  logic     rst_n,
  seg_mux_if.slave bus,
  output logic     dbg_state
);
  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int DW         = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg_mux_ctrl: NUM_DIGITS must be in 2..8");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("seg_mux_ctrl: DWELL_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seg_mux_ctrl: BLANK_CYCLES must be >= 1");
  end

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            num_q, num_d;
  logic [NUM_DIGITS-1:0] dig_en_n_q, dig_en_n_d;
  logic                  frame_done_q, frame_done_d;
  logic [DW-1:0]         active_q, active_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic                  pend_q, pend_d;

  // lead[k] = 1 when digit k must stay dark during its own slot.
  logic [NUM_DIGITS-1:0] lead;

`ifdef SEG_MUX_LZB_EN
  logic zero_above;

  // Leading-zero detection over the committed digits; digit 0 is never leading.
  always_comb begin
    lead       = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (active_q[4*k +: 4] == 4'h0);
      lead[k]    = zero_above;
    end
  end
`else
  assign lead = '0;
`endif

  // Next-state, counter, shadow/commit and registered-output computation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CNT_W'(1);
    num_d        = num_q;
    dig_en_n_d   = dig_en_n_q;
    frame_done_d = 1'b0;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;

    if (bus.load) begin
      shadow_d = bus.digits_in;
      pend_d   = 1'b1;
    end

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d    = ST_DRIVE;
          cnt_d      = '0;
          dig_en_n_d = '1;
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k) && !lead[k]) dig_en_n_d[k] = 1'b0;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          state_d    = ST_BLANK;
          cnt_d      = '0;
          dig_en_n_d = '1;
          if (idx_q == IDX_LAST) begin
            // Frame boundary: a load on this very edge bypasses the shadow.
            idx_d        = '0;
            frame_done_d = 1'b1;
            if (bus.load) begin
              active_d = bus.digits_in;
              pend_d   = 1'b0;
            end else if (pend_q) begin
              active_d = shadow_q;
              pend_d   = 1'b0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          // num only moves on BLANK entry so the decoder settles while dark.
          num_d = '0;
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) num_d = active_d[4*k +: 4];
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
      end
    endcase
  end

  // State and datapath registers; reset forces all anodes off without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      num_q        <= '0;
      dig_en_n_q   <= '1;
      frame_done_q <= 1'b0;
      active_q     <= '0;
      shadow_q     <= '0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      num_q        <= num_d;
      dig_en_n_q   <= dig_en_n_d;
      frame_done_q <= frame_done_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
    end
  end

  assign bus.num        = num_q;
  assign bus.dig_en_n   = dig_en_n_q;
  assign bus.frame_done = frame_done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// tb_seg_mux_ctrl: bench for seg_mux_ctrl with NUM_DIGITS=2, DWELL=4, BLANK=2
// (12-cycle frame). A frame-position model pushes the expected
// {frame_done, drive, dig_en_n, num} word after every clock edge; a negedge
// monitor pops and compares it against the DUT.
module tb_seg_mux_ctrl;
  localparam int ND    = 2;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DWELL + BLANK;
  localparam int FRAME = ND * SLOT;
  localparam int W     = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic dbg_state;

  seg_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_mux_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_pops   = 0;

  int           t_pos    = 0;
  logic [7:0]   m_active = 8'h00;
  logic [7:0]   m_shadow = 8'h00;
  logic         m_pend   = 1'b0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected outputs from the position inside the frame.
  function automatic logic [W-1:0] exp_word(input int p, input logic fd, input logic [7:0] act);
    int         slot  = p / SLOT;
    logic       drive = ((p % SLOT) >= BLANK);
    logic [1:0] den   = 2'b11;
    logic [3:0] n     = (slot == 0) ? act[3:0] : act[7:4];
    if (drive) den[slot] = 1'b0;
`ifdef SEG_MUX_LZB_EN
    if (drive && slot == 1 && act[7:4] == 4'h0) den = 2'b11;
`endif
    return {fd, drive, den, n};
  endfunction

  // Reference model: advances frame position and committed digits each edge.
  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        t_pos    = 0;
        m_active = 8'h00;
        m_shadow = 8'h00;
        m_pend   = 1'b0;
      end else begin
        t_pos = (t_pos == FRAME - 1) ? 0 : t_pos + 1;
        if (t_pos == 0) begin
          if (bus.load) begin
            m_active = bus.digits_in;
            m_pend   = 1'b0;
          end else if (m_pend) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
          end
        end else if (bus.load) begin
          m_shadow = bus.digits_in;
          m_pend   = 1'b1;
        end
        exp_q.push_back(exp_word(t_pos, (t_pos == 0), m_active));
      end
    end
  end

  // Monitor: compare the DUT outputs on the falling edge.
  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_pops++;
        check("out", {8'h00, bus.frame_done, dbg_state, bus.dig_en_n, bus.num}, {8'h00, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge: holds load for exactly one rising edge.
  task automatic pulse_load(input logic [7:0] d);
    bus.digits_in = d;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
    bus.digits_in = 8'($urandom_range(0, 255));
  endtask

  // Returns at a negedge where the model frame position equals p.
  task automatic wait_pos(input int p);
    int n = 0;
    @(negedge clk);
    while (t_pos != p && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("wait_pos", 16'(t_pos), 16'(p));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = 8'h00;

    // Reset held for 3 cycles: everything dark.
    repeat (3) begin
      @(negedge clk);
      check("rst_den", 16'(bus.dig_en_n), 16'h0003);
      check("rst_num", 16'(bus.num), 16'h0000);
      check("rst_fd", 16'(bus.frame_done), 16'h0000);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("first_drive", 16'(bus.dig_en_n), 16'h0002);

    // Load during frame 0, shown from frame 1.
    pulse_load(8'hA5);
    repeat (2 * FRAME) @(negedge clk);

    // Two loads in one frame: last wins, the first never shows.
    wait_pos(3);
    pulse_load(8'h3C);
    repeat (2) @(negedge clk);
    pulse_load(8'h12);
    repeat (2 * FRAME) @(negedge clk);

    // Load sampled on the boundary edge itself: bypass into the new frame.
    wait_pos(FRAME - 1);
    pulse_load(8'h77);
    repeat (2 * FRAME) @(negedge clk);

    // Leading-zero cases (expectations depend on the macro).
    wait_pos(4);
    pulse_load(8'h07);
    repeat (2 * FRAME) @(negedge clk);
    wait_pos(4);
    pulse_load(8'h00);
    repeat (2 * FRAME) @(negedge clk);

    // Async reset dropped mid-DRIVE, between edges.
    wait_pos(4);
    pulse_load(8'h5A);
    repeat (2 * FRAME) @(negedge clk);
    wait_pos(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_den", 16'(bus.dig_en_n), 16'h0003);
    check("arst_num", 16'(bus.num), 16'h0000);
    check("arst_fd", 16'(bus.frame_done), 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME + 2) @(negedge clk);

    check("sb_pops", 16'(n_pops > 100), 16'h0001);
    check("sb_drain", 16'(exp_q.size() <= 1), 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
